// File: rtl/noise_inject_pipe.sv
// Channel-noise injector: pipelined binary search of a uniform random word over a
// loadable CDF table, mapping to a noise value that is added to the signal with saturation.
module noise_inject_pipe #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int URNG_WIDTH        = 64,
  parameter int LOG2_BINS         = 7,
  parameter int NOISE_MIN         = -191,
  parameter int NOISE_STEP        = 3,
  parameter int NOISE_WIDTH       = SIGNAL_RESOLUTION + 1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 en,
  input  logic [URNG_WIDTH-1:0]                rnd_in,
  input  logic                                 rnd_valid,
  input  logic signed [SIGNAL_RESOLUTION-1:0]  sig_in,
  input  logic                                 sig_valid,
  input  logic                                 noise_en,
  input  logic                                 bypass,
  input  logic                                 cfg_we,
  input  logic [LOG2_BINS-1:0]                 cfg_addr,
  input  logic [URNG_WIDTH-1:0]                cfg_data,
  output logic signed [SIGNAL_RESOLUTION-1:0]  sig_out,
  output logic                                 sig_out_valid,
  output logic signed [NOISE_WIDTH-1:0]        noise_out,
  output logic [15:0]                          underrun_cnt
);

  localparam int NBINS = 1 << LOG2_BINS;
  localparam int SUM_W = SIGNAL_RESOLUTION + 2;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (SIGNAL_RESOLUTION - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (SIGNAL_RESOLUTION - 1)));

  logic [URNG_WIDTH-1:0]                cdf_r [NBINS-1];
  logic signed [NOISE_WIDTH-1:0]        tok_r;
  logic                                 tok_v_r;
  logic signed [31:0]                   map_full_s;
  logic signed [NOISE_WIDTH-1:0]        map_s;
  logic signed [NOISE_WIDTH-1:0]        n_s;
  logic signed [SUM_W-1:0]              sum_s;
  logic signed [SIGNAL_RESOLUTION-1:0]  sat_s;
  logic signed [SIGNAL_RESOLUTION-1:0]  sig_out_r, sig_out_nxt_s;
  logic                                 sig_out_valid_r, sig_out_valid_nxt_s;
  logic signed [NOISE_WIDTH-1:0]        noise_out_r, noise_out_nxt_s;
  logic [15:0]                          underrun_r, underrun_nxt_s;

  // Threshold table: all ones at reset, top address has no entry and is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < NBINS - 1; j++) cdf_r[j] <= '1;
    end else begin
      for (int j = 0; j < NBINS - 1; j++) begin
        if (cfg_we && (cfg_addr == LOG2_BINS'(j))) cdf_r[j] <= cfg_data;
      end
    end
  end

  for (genvar s = 0; s < LOG2_BINS; s++) begin : g_stage
    localparam logic [LOG2_BINS-1:0] STEP = LOG2_BINS'(1) << (LOG2_BINS - 1 - s);
    logic [URNG_WIDTH-1:0] rnd_r, in_rnd_s;
    logic [LOG2_BINS-1:0]  p_r, in_p_s, probe_s;
    logic                  v_r, in_v_s;

    if (s == 0) begin : g_first
      assign in_rnd_s = rnd_in;
      assign in_p_s   = '0;
      assign in_v_s   = rnd_valid;
    end else begin : g_next
      assign in_rnd_s = g_stage[s-1].rnd_r;
      assign in_p_s   = g_stage[s-1].p_r;
      assign in_v_s   = g_stage[s-1].v_r;
    end

    // Probe is the last bin of the lower half of the still-open range.
    assign probe_s = in_p_s + STEP - LOG2_BINS'(1);

    // Search stage register: set this stage's prefix bit when rnd clears the probe.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rnd_r <= '0;
        p_r   <= '0;
        v_r   <= 1'b0;
      end else if (en) begin
        rnd_r <= in_rnd_s;
        p_r   <= (in_rnd_s >= cdf_r[probe_s]) ? (in_p_s + STEP) : in_p_s;
        v_r   <= in_v_s;
      end
    end
  end

  assign map_full_s = NOISE_MIN + NOISE_STEP * int'(g_stage[LOG2_BINS-1].p_r);
  assign map_s      = map_full_s[NOISE_WIDTH-1:0];

  // Map stage register: head token presented to the combiner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tok_r   <= '0;
      tok_v_r <= 1'b0;
    end else if (en) begin
      tok_r   <= map_s;
      tok_v_r <= g_stage[LOG2_BINS-1].v_r;
    end
  end

  assign n_s   = noise_en ? tok_r : '0;
  assign sum_s = SUM_W'(sig_in) + SUM_W'(n_s);

  // Saturating clamp of the widened sum to the signal range.
  always_comb begin
    sat_s = sum_s[SIGNAL_RESOLUTION-1:0];
    if (sum_s > SAT_MAX) begin
      sat_s = SAT_MAX[SIGNAL_RESOLUTION-1:0];
    end else if (sum_s < SAT_MIN) begin
      sat_s = SAT_MIN[SIGNAL_RESOLUTION-1:0];
    end else begin
      sat_s = sum_s[SIGNAL_RESOLUTION-1:0];
    end
  end

  // Combine decision: bypass, noisy sample, or underrun passthrough.
  always_comb begin
    sig_out_nxt_s       = sig_out_r;
    noise_out_nxt_s     = noise_out_r;
    sig_out_valid_nxt_s = 1'b0;
    underrun_nxt_s      = underrun_r;
    if (sig_valid) begin
      sig_out_valid_nxt_s = 1'b1;
      if (bypass) begin
        sig_out_nxt_s   = sig_in;
        noise_out_nxt_s = '0;
      end else if (tok_v_r) begin
        sig_out_nxt_s   = sat_s;
        noise_out_nxt_s = n_s;
      end else begin
        sig_out_nxt_s   = sig_in;
        noise_out_nxt_s = '0;
        if (underrun_r != 16'hFFFF) begin
          underrun_nxt_s = underrun_r + 16'd1;
        end else begin
          underrun_nxt_s = underrun_r;
        end
      end
    end else begin
      sig_out_valid_nxt_s = 1'b0;
    end
  end

  // Output registers; en=0 freezes everything including the valid flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_out_r       <= '0;
      sig_out_valid_r <= 1'b0;
      noise_out_r     <= '0;
      underrun_r      <= 16'd0;
    end else if (en) begin
      sig_out_r       <= sig_out_nxt_s;
      sig_out_valid_r <= sig_out_valid_nxt_s;
      noise_out_r     <= noise_out_nxt_s;
      underrun_r      <= underrun_nxt_s;
    end
  end

  assign sig_out       = sig_out_r;
  assign sig_out_valid = sig_out_valid_r;
  assign noise_out     = noise_out_r;
  assign underrun_cnt  = underrun_r;

endmodule

// File: tb/tb_noise_inject_pipe.sv
// Scoreboard bench for noise_inject_pipe: directed rnd/sig vectors with hand-computed
// expected outputs queued at issue time and checked by an independent monitor.
module tb_noise_inject_pipe;

  localparam logic [63:0] ONES = '1;
  localparam logic [63:0] R63  = 64'd63 << 57;

  logic               clk = 1'b0;
  logic               rstn, en, rnd_valid, sig_valid, noise_en, bypass, cfg_we;
  logic [63:0]        rnd_in, cfg_data;
  logic signed [7:0]  sig_in;
  logic [6:0]         cfg_addr;
  logic signed [7:0]  sig_out;
  logic               sig_out_valid;
  logic signed [8:0]  noise_out;
  logic [15:0]        underrun_cnt;
  logic               en_q = 1'b0;

  typedef struct packed {
    logic signed [7:0] s;
    logic signed [8:0] n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  noise_inject_pipe dut (
    .clk(clk), .rstn(rstn), .en(en), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .sig_in(sig_in), .sig_valid(sig_valid), .noise_en(noise_en), .bypass(bypass),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .sig_out(sig_out), .sig_out_valid(sig_out_valid), .noise_out(noise_out),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One cycle of stimulus; a valid sig under en=1 queues its expected output.
  task automatic step(input logic rv, input logic [63:0] r, input logic sv, input int s,
                      input int es, input int ne);
    rnd_valid = rv;
    rnd_in    = r;
    sig_valid = sv;
    sig_in    = 8'(s);
    if (sv && en) q.push_back(exp_t'{s: 8'(es), n: 9'(ne)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 0, 0, 0);
  endtask

  always @(posedge clk) en_q <= en;

  // Monitor: every emitted sample must match the next queued expectation.
  always @(negedge clk) begin
    if (rstn && en_q && sig_out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got sig_out=%0d with no expectation queued", sig_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sig_out", sig_out, e.s);
        check("noise_out", noise_out, e.n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en = 1'b1; noise_en = 1'b1; bypass = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; rnd_in = '0; rnd_valid = 1'b0;
    sig_in = '0; sig_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sig_out", sig_out, 0);
    check("rst_valid", sig_out_valid, 0);
    check("rst_noise", noise_out, 0);
    check("rst_underrun", underrun_cnt, 0);
    rstn = 1'b1;

    // All-ones table: rnd 0 -> bin 0, rnd all ones -> bin 127.
    step(1'b1, 64'd0, 1'b0, 0, 0, 0);
    step(1'b1, ONES, 1'b0, 0, 0, 0);
    idle(6);
    step(1'b0, 64'd0, 1'b1, 5, -128, -191);
    step(1'b0, 64'd0, 1'b1, 5, 127, 190);
    idle(2);

    // Uniform table.
    for (int j = 0; j < 127; j++) begin
      cfg_we = 1'b1; cfg_addr = 7'(j); cfg_data = 64'(j + 1) << 57;
      @(posedge clk);
      #1;
    end
    cfg_we = 1'b0;
    step(1'b1, 64'd0, 1'b0, 0, 0, 0);
    step(1'b1, ONES, 1'b0, 0, 0, 0);
    step(1'b1, R63, 1'b0, 0, 0, 0);
    idle(5);
    step(1'b0, 64'd0, 1'b1, 10, -128, -191);
    step(1'b0, 64'd0, 1'b1, 10, 127, 190);
    step(1'b0, 64'd0, 1'b1, 10, 8, -2);
    idle(2);

    // Bypass with empty pipeline, then noise_en=0 with a valid token.
    check("pre_bypass_underrun", underrun_cnt, 0);
    bypass = 1'b1;
    step(1'b0, 64'd0, 1'b1, -50, -50, 0);
    bypass = 1'b0;
    idle(1);
    check("bypass_underrun", underrun_cnt, 0);
    noise_en = 1'b0;
    step(1'b1, ONES, 1'b0, 0, 0, 0);
    idle(7);
    step(1'b0, 64'd0, 1'b1, 100, 100, 0);
    noise_en = 1'b1;
    idle(1);
    check("noise_en_underrun", underrun_cnt, 0);

    // Stall for 3 cycles mid-stream; pairing counts only en=1 cycles.
    step(1'b1, 64'd0, 1'b0, 0, 0, 0);
    step(1'b1, ONES, 1'b0, 0, 0, 0);
    bypass = 1'b1;
    step(1'b1, R63, 1'b1, 33, 33, 0);
    bypass = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'd12345, 1'b1, 99, 0, 0);
      check("stall_sig_out", sig_out, 33);
      check("stall_valid", sig_out_valid, 1);
      check("stall_noise", noise_out, 0);
    end
    en = 1'b1;
    idle(5);
    step(1'b0, 64'd0, 1'b1, 0, -128, -191);
    step(1'b0, 64'd0, 1'b1, 0, 127, 190);
    step(1'b0, 64'd0, 1'b1, 0, -2, -2);
    idle(2);

    // Live write of cdf[63]=0 while rnd=1<<56 streams in.
    for (int i = 0; i < 20; i++) begin
      cfg_we = (i == 4); cfg_addr = 7'd63; cfg_data = 64'd0;
      if (i < 8)       step(1'b1, 64'd1 << 56, 1'b0, 0, 0, 0);
      else if (i < 12) step(1'b1, 64'd1 << 56, 1'b1, 20, -128, -191);
      else if (i < 13) step(1'b0, 64'd0, 1'b1, 20, -128, -191);
      else             step(1'b0, 64'd0, 1'b1, 20, 21, 1);
    end
    cfg_we = 1'b0;
    idle(10);

    // Underrun: empty pipeline, sig every cycle.
    check("pre_underrun", underrun_cnt, 0);
    for (int i = 1; i <= 5; i++) step(1'b0, 64'd0, 1'b1, i, i, 0);
    check("underrun_5", underrun_cnt, 5);
    force dut.underrun_r = 16'hFFFE;
    #1;
    release dut.underrun_r;
    step(1'b0, 64'd0, 1'b1, 7, 7, 0);
    check("underrun_max", underrun_cnt, 65535);
    step(1'b0, 64'd0, 1'b1, 7, 7, 0);
    check("underrun_sat", underrun_cnt, 65535);

    // Mid-stream asynchronous reset.
    step(1'b1, ONES, 1'b0, 0, 0, 0);
    step(1'b1, ONES, 1'b0, 0, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_sig_out", sig_out, 0);
    check("mid_rst_valid", sig_out_valid, 0);
    check("mid_rst_noise", noise_out, 0);
    check("mid_rst_underrun", underrun_cnt, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1, R63, 1'b0, 0, 0, 0);
    step(1'b1, ONES, 1'b0, 0, 0, 0);
    idle(6);
    step(1'b0, 64'd0, 1'b1, 5, -128, -191);
    step(1'b0, 64'd0, 1'b1, 5, 127, 190);
    idle(3);
    check("post_rst_underrun", underrun_cnt, 0);
    check("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
